// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit: FSM state encoding, control
// bundle constants and the legal range for the load-use latency.
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hcu_state_e;

  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 7;

  // Wide enough to hold LOAD_LAT_MAX-1 remaining stall cycles.
  localparam int STALL_CNT_W = 3;

  typedef struct packed {
    logic pc_write;
    logic stall;
    logic noop;
    logic flush;
    logic freeze;
  } hcu_ctrl_t;

  localparam hcu_ctrl_t CTRL_RESET  = 5'b00000;
  localparam hcu_ctrl_t CTRL_RUN    = 5'b10000;
  localparam hcu_ctrl_t CTRL_STALL  = 5'b01100;
  localparam hcu_ctrl_t CTRL_FREEZE = 5'b01001;

  function automatic bit load_lat_legal(input int lat);
    return (lat >= LOAD_LAT_MIN) && (lat <= LOAD_LAT_MAX);
  endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter used for hazard statistics.
// Only present when HAZARD_PERF_EN is defined.
`ifdef HAZARD_PERF_EN
module hazard_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Sticks at all-ones once reached.
  always_comb begin
    count_d = count_q;
    if (inc_i && !(&count_q)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`endif

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, memory-busy freeze, branch flush.
// Defining HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic [REG_AW-1:0] EX_Rd_i,
  input  logic [REG_AW-1:0] Rs1_i,
  input  logic [REG_AW-1:0] Rs2_i,
  input  logic              Rs1Used_i,
  input  logic              Rs2Used_i,
  input  logic              Branch_i,
  input  logic              MemBusy_i,
  output logic              PCWrite_o,
  output logic              Stall_o,
  output logic              NoOp_o,
  output logic              Flush_o,
  output logic              Freeze_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  StallCnt_o,
  output logic [CNT_W-1:0]  FlushCnt_o
`endif
);

  localparam logic [STALL_CNT_W-1:0] LAT_M1 = STALL_CNT_W'(LOAD_LAT - 1);

  generate
    if (!load_lat_legal(LOAD_LAT)) begin : g_bad_load_lat
      $error("hazard_control_unit: LOAD_LAT must be within 1..7");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("hazard_control_unit: CNT_W must be at least 1");
    end
  endgenerate

  hcu_state_e             state_q;
  hcu_state_e             state_d;
  hcu_state_e             eff_state;
  logic [STALL_CNT_W-1:0] cnt_q;
  logic [STALL_CNT_W-1:0] cnt_d;
  logic                   rs1_hit;
  logic                   rs2_hit;
  logic                   hit;
  hcu_ctrl_t              ctrl;

  assign rs1_hit = Rs1Used_i && (Rs1_i == EX_Rd_i);
  assign rs2_hit = Rs2Used_i && (Rs2_i == EX_Rd_i);
  assign hit     = MemRead_i && (EX_Rd_i != '0) && (rs1_hit || rs2_hit);

  // Once memory is ready again, MEM_WAIT behaves as whichever state its saved count implies.
  always_comb begin
    eff_state = state_q;
    if (state_q == ST_MEM_WAIT) begin
      eff_state = (cnt_q != '0) ? ST_LD_STALL : ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = eff_state;
    cnt_d   = cnt_q;
    if (MemBusy_i) begin
      state_d = ST_MEM_WAIT;
    end else begin
      case (eff_state)
        ST_LD_STALL: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - STALL_CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          if (hit) begin
            cnt_d   = LAT_M1;
            state_d = (LAT_M1 != '0) ? ST_LD_STALL : ST_IDLE;
          end
        end
      endcase
    end
  end

  // Outputs depend on rst_i directly so they clear without waiting for a clock.
  always_comb begin
    ctrl = CTRL_RUN;
    if (rst_i) begin
      ctrl = CTRL_RESET;
    end else if (MemBusy_i) begin
      ctrl = CTRL_FREEZE;
    end else begin
      case (eff_state)
        ST_LD_STALL: begin
          if (cnt_q != '0) begin
            ctrl = CTRL_STALL;
          end
        end
        default: begin
          if (hit) begin
            ctrl = CTRL_STALL;
          end
        end
      endcase
    end
    ctrl.flush = Branch_i && !ctrl.stall && !ctrl.freeze && !rst_i;
  end

  assign PCWrite_o = ctrl.pc_write;
  assign Stall_o   = ctrl.stall;
  assign NoOp_o    = ctrl.noop;
  assign Flush_o   = ctrl.flush;
  assign Freeze_o  = ctrl.freeze;

`ifdef HAZARD_PERF_EN
  hazard_perf_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (Stall_o),
    .count_o(StallCnt_o)
  );

  hazard_perf_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (Flush_o),
    .count_o(FlushCnt_o)
  );
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: two instances (LOAD_LAT 1 and 3)
// share random and directed stimulus; a reference model predicts each cycle.
module tb_hazard_control_unit;
  localparam int AW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst  = 1'b1;
  logic          mr   = 1'b0;
  logic          u1   = 1'b0;
  logic          u2   = 1'b0;
  logic          br   = 1'b0;
  logic          busy = 1'b0;
  logic [AW-1:0] rd   = '0;
  logic [AW-1:0] rs1  = '0;
  logic [AW-1:0] rs2  = '0;

  logic pc1, st1, no1, fl1, fr1;
  logic pc3, st3, no3, fl3, fr3;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] sc1, fc1, sc3, fc3;
`endif

  hazard_control_unit #(.REG_AW(AW), .LOAD_LAT(1), .CNT_W(CW)) dut1 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(mr), .EX_Rd_i(rd), .Rs1_i(rs1), .Rs2_i(rs2),
    .Rs1Used_i(u1), .Rs2Used_i(u2), .Branch_i(br), .MemBusy_i(busy),
    .PCWrite_o(pc1), .Stall_o(st1), .NoOp_o(no1), .Flush_o(fl1), .Freeze_o(fr1)
`ifdef HAZARD_PERF_EN
    , .StallCnt_o(sc1), .FlushCnt_o(fc1)
`endif
  );

  hazard_control_unit #(.REG_AW(AW), .LOAD_LAT(3), .CNT_W(CW)) dut3 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(mr), .EX_Rd_i(rd), .Rs1_i(rs1), .Rs2_i(rs2),
    .Rs1Used_i(u1), .Rs2Used_i(u2), .Branch_i(br), .MemBusy_i(busy),
    .PCWrite_o(pc3), .Stall_o(st3), .NoOp_o(no3), .Flush_o(fl3), .Freeze_o(fr3)
`ifdef HAZARD_PERF_EN
    , .StallCnt_o(sc3), .FlushCnt_o(fc3)
`endif
  );

  // ctl bit order: PCWrite, Stall, NoOp, Flush, Freeze
  typedef struct {
    logic [4:0] ctl;
    int         sc;
    int         fc;
    int         cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int total = 0;
  int bad = 0;
  int cycle_no = 0;

  // Per-instance model: stall cycles still owed, pending release cycle, event counts.
  int lat_of[2] = '{1, 3};
  int owed[2]   = '{0, 0};
  int rel[2]    = '{0, 0};
  int msc[2]    = '{0, 0};
  int mfc[2]    = '{0, 0};

  task automatic model_step(input int k, output exp_t e);
    logic pcw, stall, noop, fl, fr, hazard;
    int sat;
    sat = (1 << CW) - 1;
    hazard = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    pcw = 0; stall = 0; noop = 0; fr = 0;
    if (rst) begin
      owed[k] = 0; rel[k] = 0; msc[k] = 0; mfc[k] = 0;
    end else if (busy) begin
      fr = 1; stall = 1; rel[k] = 0;
    end else if (owed[k] > 0) begin
      stall = 1; noop = 1; owed[k]--;
      if (owed[k] == 0) rel[k] = 1;
    end else if (rel[k] != 0) begin
      pcw = 1; rel[k] = 0;
    end else if (hazard) begin
      stall = 1; noop = 1; owed[k] = lat_of[k] - 1;
    end else begin
      pcw = 1;
    end
    fl = pcw && br;
    e.ctl = {pcw, stall, noop, fl, fr};
    e.sc  = msc[k];
    e.fc  = mfc[k];
    e.cyc = cycle_no;
    if (!rst) begin
      if (stall && msc[k] < sat) msc[k]++;
      if (fl && mfc[k] < sat) mfc[k]++;
    end
  endtask

  task automatic cyc(input logic r, input logic m, input int d, input int a, input int b,
                     input logic x, input logic y, input logic bb, input logic bz);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; mr = m; rd = AW'(d); rs1 = AW'(a); rs2 = AW'(b);
    u1 = x; u2 = y; br = bb; busy = bz;
    cycle_no++;
    model_step(0, e); q1.push_back(e);
    model_step(1, e); q3.push_back(e);
  endtask

  task automatic check_ctl(input string nm, input exp_t e, input logic [4:0] act);
    total++;
    if (act !== e.ctl) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", nm, e.cyc, act, e.ctl);
    end
  endtask

  task automatic check_cnt(input string nm, input int cyc_no, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc_no, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check_ctl("lat1_ctl", e, {pc1, st1, no1, fl1, fr1});
`ifdef HAZARD_PERF_EN
        check_cnt("lat1_stallcnt", e.cyc, int'(sc1), e.sc);
        check_cnt("lat1_flushcnt", e.cyc, int'(fc1), e.fc);
`endif
        $display("cyc=%0d rst=%b lat1 ctl=%b exp=%b", e.cyc, rst, {pc1, st1, no1, fl1, fr1}, e.ctl);
      end
      if (q3.size() > 0) begin
        e = q3.pop_front();
        check_ctl("lat3_ctl", e, {pc3, st3, no3, fl3, fr3});
`ifdef HAZARD_PERF_EN
        check_cnt("lat3_stallcnt", e.cyc, int'(sc3), e.sc);
        check_cnt("lat3_flushcnt", e.cyc, int'(fc3), e.fc);
`endif
      end
    end
  end

  initial begin
    // reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 5, 5, 0, 1, 0, 1, 0);
    // lw x5 in EX, add reading x5 in ID, then a bubble in EX
    cyc(0, 1, 5, 5, 0, 1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 5, 0, 1, 0, 0, 0);
    // x0 never hazards; unused Rs2 match; non-load match
    cyc(0, 1, 0, 0, 0, 1, 1, 0, 0);
    cyc(0, 1, 7, 1, 7, 1, 0, 0, 0);
    cyc(0, 0, 7, 7, 7, 1, 1, 0, 0);
    // memory busy for two cycles inside a stall
    cyc(0, 1, 5, 0, 5, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 5, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 5, 0, 1, 0, 1);
    repeat (4) cyc(0, 0, 0, 0, 5, 0, 1, 0, 0);
    // branch held during a stall
    cyc(0, 1, 9, 9, 9, 1, 1, 1, 0);
    repeat (3) cyc(0, 0, 0, 9, 9, 1, 1, 1, 0);
    cyc(0, 0, 0, 9, 9, 1, 1, 0, 0);
    // reset pulse mid-stall
    cyc(0, 1, 3, 3, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 3, 0, 1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 3, 0, 1, 0, 0, 0);
    // long run of back-to-back hazards drives the stall counter to saturation
    repeat (20) cyc(0, 1, 4, 4, 4, 1, 1, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // randomized traffic with small register range to make hits common
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
          $urandom_range(0, 9) < 3, $urandom_range(0, 99) < 12);
    end
    @(negedge clk);
    #1;
    total++;
    if (q1.size() + q3.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q1.size() + q3.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
